// File: rtl/mem_io_bridge_if.sv
// CPU memory bus, external RAM port and UART byte streams seen by mem_io_bridge.
// The slave modport is the bridge side; master is the CPU/RAM/UART environment.
interface mem_io_bridge_if;
    logic        rdy_in;
    logic [17:0] cpu_a_in;
    logic [7:0]  cpu_dout_in;
    logic        cpu_wr_in;
    logic [7:0]  cpu_din_out;
    logic        cpu_rdy_out;
    logic [16:0] ram_a_out;
    logic [7:0]  ram_d_out;
    logic        ram_we_out;
    logic [7:0]  ram_q_in;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic        done_out;

    modport slave (
        input  rdy_in, cpu_a_in, cpu_dout_in, cpu_wr_in, ram_q_in,
               tx_ready_in, rx_data_in, rx_valid_in,
        output cpu_din_out, cpu_rdy_out, ram_a_out, ram_d_out, ram_we_out,
               tx_data_out, tx_valid_out, rx_ready_out, done_out
    );

    modport master (
        output rdy_in, cpu_a_in, cpu_dout_in, cpu_wr_in, ram_q_in,
               tx_ready_in, rx_data_in, rx_valid_in,
        input  cpu_din_out, cpu_rdy_out, ram_a_out, ram_d_out, ram_we_out,
               tx_data_out, tx_valid_out, rx_ready_out, done_out
    );
endinterface

// File: rtl/mem_io_bridge.sv
// CPU bus bridge: RAM passthrough, unmapped gap, and I/O page with UART FIFOs,
// cycle counter snapshot and stop/done handling. Stalls the CPU while TX is full.
module mem_io_bridge #(
    parameter int          FIFO_AW = 3,
    parameter logic [31:0] CNT_RST = 32'h0000_0000
) (
    input logic            clk_in,
    input logic            rst_in,
    mem_io_bridge_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic              live, io_sel, io_wr, io_rd;
    logic [2:0]        off;
    logic [7:0]        tx_mem [DEPTH];
    logic [FIFO_AW:0]  tx_wp, tx_rp;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]        tx_wdata;
    logic [7:0]        rx_mem [DEPTH];
    logic [FIFO_AW:0]  rx_wp, rx_rp;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic [31:0]       cnt, snap;
    logic              stop, done_q, rd_ram;
    logic [7:0]        rd_byte, rd_byte_nxt;

    // tx_full comes only from pointer registers, so rdy has no path from CPU inputs
    assign live   = bus.rdy_in & ~tx_full;
    assign io_sel = (bus.cpu_a_in[17:16] == 2'b11);
    assign off    = bus.cpu_a_in[2:0];
    assign io_wr  = live & io_sel & bus.cpu_wr_in;
    assign io_rd  = live & io_sel & ~bus.cpu_wr_in;

    assign bus.cpu_rdy_out = live;
    assign bus.ram_a_out   = bus.cpu_a_in[16:0];
    assign bus.ram_d_out   = bus.cpu_dout_in;
    assign bus.ram_we_out  = live & bus.cpu_wr_in & ~bus.cpu_a_in[17];

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    // the stop write always enqueues a 0x00 marker, bypassing the zero filter
    assign tx_push  = io_wr & (((off == 3'd0) & (bus.cpu_dout_in != 8'h00)) | (off == 3'd4));
    assign tx_wdata = (off == 3'd4) ? 8'h00 : bus.cpu_dout_in;
    assign tx_pop   = ~tx_empty & bus.tx_ready_in;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign rx_push  = bus.rx_valid_in & ~rx_full;
    assign rx_pop   = io_rd & (off == 3'd0) & ~rx_empty;

    assign bus.tx_valid_out = ~tx_empty;
    assign bus.tx_data_out  = tx_mem[tx_rp[FIFO_AW-1:0]];
    assign bus.rx_ready_out = ~rx_full;
    assign bus.done_out     = done_q | (stop & tx_empty);
    assign bus.cpu_din_out  = rd_ram ? bus.ram_q_in : rd_byte;

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_wdata;
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= bus.rx_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // Byte returned by non-RAM reads; offset 4 returns the live count, since
    // the snapshot register is only loaded at this same edge.
    always_comb begin
        rd_byte_nxt = 8'h00;
        if (io_sel && !bus.cpu_wr_in) begin
            case (off)
                3'd0: if (!rx_empty) rd_byte_nxt = rx_mem[rx_rp[FIFO_AW-1:0]];
                3'd4: rd_byte_nxt = cnt[7:0];
                3'd5: rd_byte_nxt = snap[15:8];
                3'd6: rd_byte_nxt = snap[23:16];
                3'd7: rd_byte_nxt = snap[31:24];
                default: rd_byte_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt     <= CNT_RST;
            snap    <= '0;
            stop    <= 1'b0;
            done_q  <= 1'b0;
            rd_ram  <= 1'b0;
            rd_byte <= 8'h00;
        end else begin
            cnt    <= cnt + 32'd1;
            done_q <= done_q | (stop & tx_empty);
            if (io_wr && off == 3'd4) stop <= 1'b1;
            if (io_rd && off == 3'd4) snap <= cnt;
            if (live) begin
                rd_ram  <= ~bus.cpu_wr_in & ~bus.cpu_a_in[17];
                rd_byte <= rd_byte_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed vector table, hand-written corner sequences and
// random traffic checked every cycle against a queue-based behavioural model.
module tb_mem_io_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2;
    mem_io_bridge_if bus ();
    mem_io_bridge_if bus2 ();

    mem_io_bridge dut (.clk_in(clk), .rst_in(rst), .bus(bus));
    mem_io_bridge #(.CNT_RST(32'hFFFF_FFFE)) dut_wrap (.clk_in(clk), .rst_in(rst2), .bus(bus2));

    // synchronous RAM device, 1-cycle read latency
    logic [7:0] ram_dev [0:131071];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_we_out) ram_dev[bus.ram_a_out] <= bus.ram_d_out;
        ram_q <= ram_dev[bus.ram_a_out];
    end
    assign bus.ram_q_in = ram_q;

    // stimulus for the next cycle
    logic [17:0] a_v;
    logic [7:0]  d_v, rxd_v;
    logic        wr_v, rdy_v, txr_v, rxv_v, rst_v;
    // DUT outputs sampled mid-cycle
    logic        s_rdy, s_txv, s_rxr, s_done, s_we;
    logic [7:0]  s_txd, s_din, s_ram_d;
    logic [16:0] s_ram_a;
    logic [31:0] s_cnt;
    // reference model
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [7:0]  ref_mem [int];
    logic        stop_m, done_seen, chk_din;
    logic [7:0]  exp_din;
    logic [31:0] cnt_m, snap_m;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        a_v = 18'h20000; wr_v = 1'b0; d_v = 8'h00; rxv_v = 1'b0; rdy_v = 1'b1;
    endtask

    task automatic cycle();
        logic live, rx_acc;
        logic [2:0] off;
        int k;
        @(negedge clk);
        rst = rst_v;
        bus.rdy_in = rdy_v; bus.cpu_a_in = a_v; bus.cpu_dout_in = d_v; bus.cpu_wr_in = wr_v;
        bus.tx_ready_in = txr_v; bus.rx_data_in = rxd_v; bus.rx_valid_in = rxv_v;
        #1;
        s_rdy = bus.cpu_rdy_out; s_txv = bus.tx_valid_out; s_txd = bus.tx_data_out;
        s_rxr = bus.rx_ready_out; s_done = bus.done_out; s_we = bus.ram_we_out;
        s_din = bus.cpu_din_out; s_ram_a = bus.ram_a_out; s_ram_d = bus.ram_d_out;
        s_cnt = cnt_m;
        live = rdy_v && (tx_q.size() < 8);
        off = a_v[2:0];
        if (!rst_v) begin
            chk("cpu_rdy", s_rdy, live);
            chk("tx_valid", s_txv, tx_q.size() != 0);
            if (tx_q.size() != 0) chk("tx_data", s_txd, tx_q[0]);
            chk("rx_ready", s_rxr, rx_q.size() < 8);
            chk("done", s_done, done_seen || (stop_m && tx_q.size() == 0));
            chk("ram_we", s_we, live && wr_v && !a_v[17]);
            if (!a_v[17]) begin
                chk("ram_a", s_ram_a, a_v[16:0]);
                if (wr_v) chk("ram_d", s_ram_d, d_v);
            end
            if (chk_din) chk("cpu_din", s_din, exp_din);
        end
        @(posedge clk);
        if (rst_v) begin
            tx_q.delete(); rx_q.delete();
            stop_m = 1'b0; done_seen = 1'b0; cnt_m = 32'h0; snap_m = 32'h0;
            chk_din = 1'b1; exp_din = 8'h00;
        end else begin
            if (stop_m && tx_q.size() == 0) done_seen = 1'b1;
            if (tx_q.size() != 0 && txr_v) void'(tx_q.pop_front());
            rx_acc = rxv_v && (rx_q.size() < 8);
            chk_din = 1'b0;
            if (live && wr_v) begin
                k = int'(a_v[16:0]);
                if (!a_v[17]) ref_mem[k] = d_v;
                else if (a_v[16]) begin
                    if (off == 3'd0 && d_v != 8'h00) tx_q.push_back(d_v);
                    if (off == 3'd4) begin tx_q.push_back(8'h00); stop_m = 1'b1; end
                end
            end else if (live) begin
                chk_din = 1'b1;
                exp_din = 8'h00;
                k = int'(a_v[16:0]);
                if (!a_v[17]) exp_din = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
                else if (a_v[16]) begin
                    if (off == 3'd0 && rx_q.size() != 0) exp_din = rx_q.pop_front();
                    else if (off == 3'd4) begin exp_din = cnt_m[7:0]; snap_m = cnt_m; end
                    else if (off >= 3'd5) exp_din = 8'(snap_m >> (8 * (int'(off) - 4)));
                end
            end
            if (rx_acc) rx_q.push_back(rxd_v);
            cnt_m = cnt_m + 32'd1;
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        set_idle();
        repeat (2) cycle();
        rst_v = 1'b0;
    endtask

    typedef struct {
        logic [17:0] a;
        logic [7:0]  d;
        logic        wr;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk;
        logic [7:0]  din;
        logic        we;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] msg [8];

    initial begin
        int got, r;
        logic [31:0] n, rc;
        logic [7:0] bv;
        for (int i = 0; i < 131072; i++) ram_dev[i] = 8'h00;
        rst = 1'b1; rst2 = 1'b1; txr_v = 1'b0; rxd_v = 8'h00;
        bus2.rdy_in = 1'b1; bus2.cpu_a_in = 18'h20000; bus2.cpu_dout_in = 8'h00;
        bus2.cpu_wr_in = 1'b0; bus2.ram_q_in = 8'h00; bus2.tx_ready_in = 1'b0;
        bus2.rx_data_in = 8'h00; bus2.rx_valid_in = 1'b0;
        msg = '{8'h48, 8'h69, 8'h21, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        //            a          d      wr    rxv   rxd    chk   din    we
        tbl[0] = '{18'h00100, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{18'h00100, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{18'h20000, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 8'hA5, 1'b0};
        tbl[3] = '{18'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{18'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        tbl[5] = '{18'h30001, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[6] = '{18'h20000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};

        do_reset();
        rdy_v = 1'b0;
        cycle();
        chk("rst_din", s_din, 8'h00);
        chk("rst_txv", s_txv, 1'b0);
        chk("rst_rxr", s_rxr, 1'b1);
        chk("rst_done", s_done, 1'b0);
        chk("rst_rdy_follows", s_rdy, 1'b0);
        set_idle();
        cycle();
        chk("rst_rdy_high", s_rdy, 1'b1);

        for (int i = 0; i < 7; i++) begin
            a_v = tbl[i].a; d_v = tbl[i].d; wr_v = tbl[i].wr;
            rxv_v = tbl[i].rxv; rxd_v = tbl[i].rxd; rdy_v = 1'b1; txr_v = 1'b0;
            cycle();
            chk($sformatf("tbl%0d_we", i), s_we, tbl[i].we);
            if (tbl[i].chk) chk($sformatf("tbl%0d_din", i), s_din, tbl[i].din);
        end

        // TX backpressure: 8 pushes fill the FIFO, a held 9th write must not enter
        txr_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_v = 18'h30000; wr_v = 1'b1; d_v = msg[i];
            cycle();
        end
        d_v = 8'h5A;
        cycle();
        chk("bp_rdy_low", s_rdy, 1'b0);
        repeat (2) cycle();
        chk("bp_head", s_txd, 8'h48);
        set_idle();
        cycle();
        txr_v = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            cycle();
            if (s_txv) begin
                chk($sformatf("bp_drain%0d", got), s_txd, msg[got]);
                got++;
            end
        end
        chk("bp_drain_count", got, 8);
        cycle();
        chk("bp_rdy_back", s_rdy, 1'b1);

        // zero filter
        a_v = 18'h30000; wr_v = 1'b1; d_v = 8'h00;
        cycle();
        set_idle();
        cycle();
        chk("zero_no_push", s_txv, 1'b0);

        // RX fill to full, then drain in order
        for (int i = 0; i < 8; i++) begin
            rxv_v = 1'b1; rxd_v = 8'h80 + 8'(i);
            cycle();
        end
        rxd_v = 8'hEE;
        cycle();
        chk("rx_full_ready", s_rxr, 1'b0);
        rxv_v = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin a_v = 18'h30000; wr_v = 1'b0; end
            else set_idle();
            cycle();
            if (i > 0) begin
                bv = 8'h80 + 8'(i - 1);
                chk($sformatf("rx_rd%0d", i - 1), s_din, bv);
            end
        end

        // counter snapshot over four consecutive reads
        n = 32'h0; rc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin a_v = 18'h30004 + 18'(i); wr_v = 1'b0; end
            else set_idle();
            cycle();
            if (i == 0) n = s_cnt;
            else rc[8*(i-1) +: 8] = s_din;
        end
        chk("cnt_snapshot", rc, n);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) a_v = {1'b0, 1'($urandom_range(0, 1)), 12'h000, 4'($urandom_range(0, 15))};
            else if (r < 6) a_v = {2'b10, 16'($urandom)};
            else a_v = 18'h30000 + 18'($urandom_range(0, 7));
            wr_v  = ($urandom_range(0, 2) == 0);
            d_v   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rdy_v = ($urandom_range(0, 9) != 0);
            txr_v = 1'($urandom_range(0, 1));
            rxv_v = ($urandom_range(0, 9) < 4);
            rxd_v = 8'($urandom);
            cycle();
        end

        // reset mid-operation flushes queued TX bytes
        set_idle();
        txr_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_v = 18'h30000; wr_v = 1'b1; d_v = 8'h11 * 8'(i + 1);
            cycle();
        end
        do_reset();
        cycle();
        chk("flush_txv", s_txv, 1'b0);

        // stop: 0x00 marker, done once drained, sticky, cleared by reset
        txr_v = 1'b1;
        a_v = 18'h30004; wr_v = 1'b1; d_v = 8'h77;
        cycle();
        set_idle();
        cycle();
        chk("stop_txv", s_txv, 1'b1);
        chk("stop_txd", s_txd, 8'h00);
        chk("stop_done_early", s_done, 1'b0);
        cycle();
        chk("stop_done", s_done, 1'b1);
        repeat (3) cycle();
        chk("stop_done_sticky", s_done, 1'b1);
        do_reset();
        cycle();
        chk("done_after_rst", s_done, 1'b0);

        // counter wrap on an instance that resets near the top of the range
        @(negedge clk); rst2 = 1'b0; bus2.cpu_a_in = 18'h20000;
        @(negedge clk); bus2.cpu_a_in = 18'h30004;
        @(negedge clk); bus2.cpu_a_in = 18'h30007;
        #1 chk("wrap_ffffffff_b0", bus2.cpu_din_out, 8'hFF);
        @(negedge clk); bus2.cpu_a_in = 18'h30004;
        #1 chk("wrap_ffffffff_b3", bus2.cpu_din_out, 8'hFF);
        @(negedge clk); bus2.cpu_a_in = 18'h30007;
        #1 chk("wrap_after_b0", bus2.cpu_din_out, 8'h01);
        @(negedge clk); bus2.cpu_a_in = 18'h20000;
        #1 chk("wrap_after_b3", bus2.cpu_din_out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
